btn_bounce_gen: RTL and testbench

- Synthesizable button-bounce emulator. It is the driving end of the debounce path: it turns one clean press request into a realistic bouncing button waveform on `btn`.
- It feeds `debounce_pulse` in loopback benches and on-board self-test.
- Each request produces a press bounce, a clean hold, a release bounce and a settle period, then one `done` pulse.

---
 rtl/btn_bounce_pkg.sv | 20 ++
 rtl/lfsr16.sv | 16 +
 rtl/btn_bounce_gen.sv | 157 +++++++++++++++
 tb/tb_btn_bounce_gen.sv | 116 +++++++++++
 4 files changed

// File: rtl/btn_bounce_pkg.sv
// Shared types and constants for the button-bounce emulator.
package btn_bounce_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        SETTLE  = 3'd4
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running outside reset; reloads seed on reset.
module lfsr16
    import btn_bounce_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= seed;
        else     q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/btn_bounce_gen.sv
// Button-bounce emulator: one start request -> press bounce, hold, release bounce, settle, done.
// Optional macro BTN_BOUNCE_LFSR_EN randomises the bounce gap from a 16-bit LFSR.
module btn_bounce_gen
    import btn_bounce_pkg::*;
#(
    parameter int          BCNT_W     = 3,
    parameter int          HOLD_W     = 16,
    parameter int          GAP_CYCLES = 4,
    parameter int          GAP_W      = 4,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BCNT_W-1:0] bounce_n,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              btn,
    output logic              busy,
    output logic              done
);

    // One timer serves both gap and hold timing, so it must cover the widest of them.
    localparam int TMR_W = max_int(HOLD_W, max_int(GAP_W + 1, $clog2(GAP_CYCLES + 1)));
    localparam int EC_W  = BCNT_W + 1;

    if (GAP_CYCLES < 1) begin : g_gap_chk
        $error("GAP_CYCLES must be at least 1");
    end
    if (LFSR_SEED == 16'h0) begin : g_seed_chk
        $error("LFSR_SEED must be nonzero");
    end

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [EC_W-1:0]   ecnt_q, ecnt_d;
    logic [BCNT_W-1:0] n_q, n_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              btn_d, busy_d, done_d;
    logic [TMR_W-1:0]  gap;
    logic [TMR_W-1:0]  hold_eff;
    logic              tick_gap, tick_hold;

`ifdef BTN_BOUNCE_LFSR_EN
    logic [15:0]    lfsr;
    logic [GAP_W:0] gap_q;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    // Every btn transition is an edge; the gap to the next event is sampled there.
    always_ff @(posedge clk) begin
        if (rst)                gap_q <= (GAP_W + 1)'(1);
        else if (btn_d != btn)  gap_q <= (GAP_W + 1)'(lfsr[GAP_W-1:0]) + (GAP_W + 1)'(1);
    end

    assign gap = TMR_W'(gap_q);
`else
    assign gap = TMR_W'(GAP_CYCLES);
`endif

    assign hold_eff  = (hold_q == '0) ? TMR_W'(1) : TMR_W'(hold_q);
    // Timer reads 1 in the cycle of an edge, so equality marks the cycle before the next event.
    assign tick_gap  = (tmr_q == gap);
    assign tick_hold = (tmr_q == hold_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            ecnt_q  <= '0;
            n_q     <= '0;
            hold_q  <= '0;
            btn     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ecnt_q  <= ecnt_d;
            n_q     <= n_d;
            hold_q  <= hold_d;
            btn     <= btn_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TMR_W'(1);
        ecnt_d  = ecnt_q;
        n_d     = n_q;
        hold_d  = hold_q;
        btn_d   = btn;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tmr_d  = '0;
                busy_d = 1'b0;
                // The done cycle is spent in IDLE; a start there must be ignored.
                if (start && !done) begin
                    n_d     = bounce_n;
                    hold_d  = hold_len;
                    ecnt_d  = {bounce_n, 1'b0};
                    btn_d   = 1'b1;
                    busy_d  = 1'b1;
                    tmr_d   = TMR_W'(1);
                    state_d = (bounce_n == '0) ? HOLD : PRESS;
                end
            end
            PRESS: begin
                if (tick_gap) begin
                    btn_d  = ~btn;
                    tmr_d  = TMR_W'(1);
                    ecnt_d = ecnt_q - EC_W'(1);
                    if (ecnt_q == EC_W'(1)) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick_hold) begin
                    btn_d   = 1'b0;
                    tmr_d   = TMR_W'(1);
                    ecnt_d  = {n_q, 1'b0};
                    state_d = (n_q == '0) ? SETTLE : RELEASE;
                end
            end
            RELEASE: begin
                if (tick_gap) begin
                    btn_d  = ~btn;
                    tmr_d  = TMR_W'(1);
                    ecnt_d = ecnt_q - EC_W'(1);
                    if (ecnt_q == EC_W'(1)) state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (tick_gap) begin
                    done_d  = 1'b1;
                    tmr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
                btn_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Directed bench: three emulators with different gaps share stimulus; a timing model fills a scoreboard.
module tb_btn_bounce_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  bounce_n = '0;
    logic [15:0] hold_len = '0;
    logic        btn4, busy4, done4;
    logic        btn2, busy2, done2;
    logic        btn1, busy1, done1;

    logic [2:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_bounce_gen #(.GAP_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .bounce_n(bounce_n), .hold_len(hold_len),
        .btn(btn4), .busy(busy4), .done(done4));
    btn_bounce_gen #(.GAP_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .bounce_n(bounce_n), .hold_len(hold_len),
        .btn(btn2), .busy(busy2), .done(done2));
    btn_bounce_gen #(.GAP_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .bounce_n(bounce_n), .hold_len(hold_len),
        .btn(btn1), .busy(busy1), .done(done1));

    function automatic logic [2:0] pick(input int sel);
        case (sel)
            4:       return {btn4, busy4, done4};
            2:       return {btn2, busy2, done2};
            default: return {btn1, busy1, done1};
        endcase
    endfunction

    // Expected {btn,busy,done} in cycle k for a start accepted in cycle 0.
    function automatic int seq_len(input int n, input int g, input int h);
        int hh = (h == 0) ? 1 : h;
        return 1 + 2*n*g + hh + 2*n*g + g;
    endfunction

    function automatic logic [2:0] model(input int n, input int g, input int h, input int k);
        int hh = (h == 0) ? 1 : h;
        int cnt = 0;
        int p, r, d;
        if (k < 1) return 3'b000;
        p = 1 + 2*n*g;
        r = p + hh;
        d = r + 2*n*g + g;
        cnt = 1;
        for (int i = 1; i <= 2*n; i++) if (1 + g*i <= k) cnt++;
        if (r <= k) cnt++;
        for (int i = 1; i <= 2*n; i++) if (r + g*i <= k) cnt++;
        return {(cnt % 2) == 1, k <= d, k == d};
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic reset_dut(input string tag, input int sel);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_reset"}, pick(sel), 3'b000);
        rst = 1'b0;
    endtask

    // s1/s2: extra start pulses with scrambled inputs; rst_at: reset cycle; re_at: restart cycle.
    task automatic run(input string tag, input int sel, input int n, input int g, input int h,
                       input int s1, input int s2, input int rst_at, input int re_at);
        int d   = seq_len(n, g, h);
        int len = (re_at >= 0) ? re_at + d + 3 : d + 5;
        logic [2:0] e;
        reset_dut(tag, sel);
        bounce_n = 3'(n);
        hold_len = 16'(h);
        for (int k = 0; k < len; k++) begin
            start = (k == 0) || (k == s1) || (k == s2) || (k == re_at);
            rst   = (k == rst_at);
            if (s1 >= 0 && k > 0) begin
                bounce_n = 3'($urandom_range(0, 7));
                hold_len = 16'($urandom_range(0, 65535));
            end
            if (rst_at >= 0 && k + 1 > rst_at)
                e = (re_at >= 0 && k + 1 >= re_at) ? model(n, g, h, k + 1 - re_at) : 3'b000;
            else
                e = model(n, g, h, k + 1);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            check(tag, pick(sel), exp_q.pop_front());
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        run("n0_g4_h10",   4, 0, 4, 10, -1, -1, -1, -1);
        run("n1_g2_h5",    2, 1, 2, 5,  -1, -1, -1, -1);
        run("ignore_start",4, 0, 4, 10,  3, 15, -1, -1);
        run("mid_reset",   2, 1, 2, 5,  -1, -1,  6,  9);
        run("hold0_g1",    1, 0, 1, 0,  -1, -1, -1, -1);
        run("n7_g1_h3",    1, 7, 1, 3,  -1, -1, -1, -1);
        run("n3_g4_h1",    4, 3, 4, 1,  -1, -1, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
